// File: rtl/sfp_link_pkg.sv
// Shared constants for the SFP frame link: default sizes, FSM state
// encodings and the field layout of the 128-bit command/status frame.
package sfp_link_pkg;

   // Default geometry of one frame on the 32-bit transceiver stream
   localparam int C_DATA_FRAME_BIT_DEF = 128;
   localparam int C_AXIS_WIDTH_DEF     = 32;
   localparam int C_BEATS_DEF          = 4;
   localparam int C_RX_TIMEOUT_DEF     = 64;

   // TX serializer states
   localparam logic [1:0] TX_IDLE = 2'd0;
   localparam logic [1:0] TX_SEND = 2'd1;
   localparam logic [1:0] TX_DONE = 2'd2;

   // RX reassembly states
   localparam logic [1:0] RX_IDLE    = 2'd0;
   localparam logic [1:0] RX_COLLECT = 2'd1;
   localparam logic [1:0] RX_DISCARD = 2'd2;

   // Frame field offsets; beat0 (MSW) carries CMD and SLV_ID
   localparam int CMD_HI    = 127;
   localparam int CMD_LO    = 112;
   localparam int SLV_ID_HI = 111;
   localparam int SLV_ID_LO = 96;
   localparam int DATA_1_HI = 95;
   localparam int DATA_1_LO = 64;
   localparam int DATA_2_HI = 63;
   localparam int DATA_2_LO = 32;
   localparam int DATA_3_HI = 31;
   localparam int DATA_3_LO = 0;

   // Command code of a status frame
   localparam logic [15:0] STATUS_CMD = 16'h1111;

endpackage

// File: rtl/sfp_frame_link_if.sv
// One AXI4-Stream channel towards or from the SFP transceiver.
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both 1. The master holds tdata/tlast stable and keeps tvalid high until
// that edge; tvalid never depends on tready.
interface sfp_frame_link_if #(
   parameter int W = 32
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tlast;
   logic         tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sfp_frame_rx.sv
// RX reassembly: collects beats MSW first into a frame, checks framing
// (short, long, inter-beat timeout) and presents good frames with a
// one-cycle end flag. Error paths never touch the presented frame.
module sfp_frame_rx
   import sfp_link_pkg::*;
#(
   parameter int C_DATA_FRAME_BIT = C_DATA_FRAME_BIT_DEF,
   parameter int C_AXIS_WIDTH     = C_AXIS_WIDTH_DEF,
   parameter int C_BEATS          = C_BEATS_DEF,
   parameter int C_RX_TIMEOUT     = C_RX_TIMEOUT_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   sfp_frame_link_if.slave             s_axis,
   output logic [C_DATA_FRAME_BIT-1:0] rx_frame,
   output logic                        end_flag,
   output logic [7:0]                  err_cnt,
   output logic [1:0]                  state
);
   localparam int CW = $clog2(C_BEATS);
   localparam int TW = $clog2(C_RX_TIMEOUT);
   localparam int AW = C_DATA_FRAME_BIT - C_AXIS_WIDTH;
   localparam logic [CW-1:0] LAST_BEAT = CW'(C_BEATS - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(C_RX_TIMEOUT - 1);

   logic [AW-1:0] asm_q;
   logic [CW-1:0] cnt, cnt_d;
   logic [TW-1:0] timer, timer_d;
   logic [1:0]    state_d;
   logic          ready_q, accept, store, err_hit, good_hit;

   assign s_axis.tready = ready_q;
   assign accept        = s_axis.tvalid && ready_q;

   // Next-state, framing verdict and idle-timer update
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      timer_d  = timer;
      store    = 1'b0;
      err_hit  = 1'b0;
      good_hit = 1'b0;
      case (state)
         RX_IDLE: begin
            timer_d = '0;
            if (accept) begin
               if (s_axis.tlast) begin
                  err_hit = 1'b1;
               end else begin
                  store   = 1'b1;
                  cnt_d   = CW'(1);
                  state_d = RX_COLLECT;
               end
            end
         end
         RX_COLLECT: begin
            if (accept) begin
               timer_d = '0;
               if (s_axis.tlast) begin
                  state_d = RX_IDLE;
                  if (cnt == LAST_BEAT) good_hit = 1'b1;
                  else                  err_hit  = 1'b1;
               end else if (cnt == LAST_BEAT) begin
                  err_hit = 1'b1;
                  state_d = RX_DISCARD;
               end else begin
                  store = 1'b1;
                  cnt_d = cnt + CW'(1);
               end
            end else if (timer == TMO_LAST) begin
               err_hit = 1'b1;
               state_d = RX_IDLE;
            end else begin
               timer_d = timer + TW'(1);
            end
         end
         RX_DISCARD: begin
            if (accept && s_axis.tlast) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // State, assembly register, frame output and saturating error count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RX_IDLE;
         cnt      <= '0;
         timer    <= '0;
         asm_q    <= '0;
         rx_frame <= '0;
         end_flag <= 1'b0;
         err_cnt  <= '0;
         ready_q  <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         timer    <= timer_d;
         ready_q  <= 1'b1;
         end_flag <= good_hit;
         if (store)    asm_q    <= {asm_q[AW-C_AXIS_WIDTH-1:0], s_axis.tdata};
         if (good_hit) rx_frame <= {asm_q, s_axis.tdata};
         if (err_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end
endmodule

// File: rtl/sfp_frame_link.sv
// Bridge between the SFP register block and the transceiver streams:
// serializes a 128-bit TX frame into four beats (MSW first) and hands RX
// reassembly to sfp_frame_rx. The two directions share nothing but clock.
module sfp_frame_link
   import sfp_link_pkg::*;
#(
   parameter int C_DATA_FRAME_BIT = C_DATA_FRAME_BIT_DEF,
   parameter int C_AXIS_WIDTH     = C_AXIS_WIDTH_DEF,
   parameter int C_BEATS          = C_BEATS_DEF,
   parameter int C_RX_TIMEOUT     = C_RX_TIMEOUT_DEF
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESETN,
   input  logic                        i_sfp_start_flag,
   input  logic [C_DATA_FRAME_BIT-1:0] i_tx_frame,
   output logic                        o_tx_en,
   output logic [C_DATA_FRAME_BIT-1:0] o_rx_frame,
   output logic                        o_sfp_end_flag,
   sfp_frame_link_if.master            m_axis,
   sfp_frame_link_if.slave             s_axis,
   output logic                        o_tx_busy,
   output logic [7:0]                  o_tx_drop_cnt,
   output logic [7:0]                  o_rx_err_cnt,
   output logic [1:0]                  o_tx_state,
   output logic [1:0]                  o_rx_state
);
   localparam int CW = $clog2(C_BEATS);
   localparam int SW = C_DATA_FRAME_BIT - C_AXIS_WIDTH;
   localparam logic [CW-1:0] LAST_BEAT = CW'(C_BEATS - 1);

   logic [1:0]                  tx_state;
   logic [C_DATA_FRAME_BIT-1:0] tx_shreg;
   logic [CW-1:0]               tx_beat;
   logic                        tx_hs;

   // The beat on the wire is always the top word of the shift register
   assign m_axis.tdata  = tx_shreg[C_DATA_FRAME_BIT-1 -: C_AXIS_WIDTH];
   assign m_axis.tvalid = (tx_state == TX_SEND);
   assign m_axis.tlast  = (tx_state == TX_SEND) && (tx_beat == LAST_BEAT);
   assign tx_hs         = m_axis.tvalid && m_axis.tready;
   assign o_tx_en       = (tx_state == TX_DONE);
   assign o_tx_busy     = (tx_state != TX_IDLE);
   assign o_tx_state    = tx_state;

   // TX serializer: load on start, shift one word per handshake
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         tx_state <= TX_IDLE;
         tx_shreg <= '0;
         tx_beat  <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (i_sfp_start_flag) begin
                  tx_shreg <= i_tx_frame;
                  tx_beat  <= '0;
                  tx_state <= TX_SEND;
               end
            end
            TX_SEND: begin
               if (tx_hs) begin
                  tx_shreg <= {tx_shreg[SW-1:0], {C_AXIS_WIDTH{1'b0}}};
                  tx_beat  <= tx_beat + CW'(1);
                  if (tx_beat == LAST_BEAT) tx_state <= TX_DONE;
               end
            end
            TX_DONE: tx_state <= TX_IDLE;
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // Count start requests that arrive while a frame is still in flight
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         o_tx_drop_cnt <= '0;
      end else if (i_sfp_start_flag && tx_state != TX_IDLE && o_tx_drop_cnt != 8'hFF) begin
         o_tx_drop_cnt <= o_tx_drop_cnt + 8'd1;
      end
   end

   sfp_frame_rx #(
      .C_DATA_FRAME_BIT (C_DATA_FRAME_BIT),
      .C_AXIS_WIDTH     (C_AXIS_WIDTH),
      .C_BEATS          (C_BEATS),
      .C_RX_TIMEOUT     (C_RX_TIMEOUT)
   ) u_rx (
      .clk      (S_AXI_ACLK),
      .rst_n    (S_AXI_ARESETN),
      .s_axis   (s_axis),
      .rx_frame (o_rx_frame),
      .end_flag (o_sfp_end_flag),
      .err_cnt  (o_rx_err_cnt),
      .state    (o_rx_state)
   );
endmodule

// File: tb/tb_sfp_frame_link.sv
// Bench for sfp_frame_link: directed scenarios plus a randomized phase,
// all checked against a frame-level reference model evaluated on the
// falling edge.
module tb_sfp_frame_link;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         start = 1'b0;
   logic [127:0] tx_frame = '0;
   logic         tx_en, end_flag, tx_busy;
   logic [127:0] rx_frame;
   logic [7:0]   drop_cnt, err_cnt;
   logic [1:0]   tx_state, rx_state;

   sfp_frame_link_if #(.W(32)) m_axis ();
   sfp_frame_link_if #(.W(32)) s_axis ();

   sfp_frame_link dut (
      .S_AXI_ACLK       (clk),
      .S_AXI_ARESETN    (rst_n),
      .i_sfp_start_flag (start),
      .i_tx_frame       (tx_frame),
      .o_tx_en          (tx_en),
      .o_rx_frame       (rx_frame),
      .o_sfp_end_flag   (end_flag),
      .m_axis           (m_axis),
      .s_axis           (s_axis),
      .o_tx_busy        (tx_busy),
      .o_tx_drop_cnt    (drop_cnt),
      .o_rx_err_cnt     (err_cnt),
      .o_tx_state       (tx_state),
      .o_rx_state       (rx_state)
   );

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0]  exp_q[$];   // TX beats still owed for the frame in flight
   logic [31:0]  pkt[$];     // RX beats of the packet being received
   bit           mon_en = 1'b0;
   bit           tx_en_now = 1'b0, end_now = 1'b0, long_f = 1'b0, rdy_exp = 1'b0;
   int           idle_cnt = 0;
   logic [7:0]   drop_exp = '0, err_exp = '0;
   logic [127:0] frame_exp = '0;

   always @(negedge clk) begin
      if (mon_en) begin
         bit tx_en_next, end_next, busy;
         check("tx_valid", m_axis.tvalid, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            check("tx_data", m_axis.tdata, exp_q[0]);
            check("tx_last", m_axis.tlast, exp_q.size() == 1);
         end
         check("tx_en", tx_en, tx_en_now);
         busy = (exp_q.size() != 0) || tx_en_now;
         check("tx_busy", tx_busy, busy);
         check("drop_cnt", drop_cnt, drop_exp);
         check("end_flag", end_flag, end_now);
         check("rx_frame", rx_frame, frame_exp);
         check("err_cnt", err_cnt, err_exp);
         check("rx_ready", s_axis.tready, rdy_exp);
         if (!rst_n) begin
            exp_q.delete(); pkt.delete();
            tx_en_now = 0; end_now = 0; long_f = 0; rdy_exp = 0; idle_cnt = 0;
            drop_exp = '0; err_exp = '0; frame_exp = '0;
         end else begin
            // TX: one frame at a time, words MSW first
            tx_en_next = 0;
            if (exp_q.size() != 0 && m_axis.tready) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) tx_en_next = 1;
            end
            if (start) begin
               if (!busy) begin
                  for (int b = 3; b >= 0; b--) exp_q.push_back(tx_frame[b*32 +: 32]);
               end else if (drop_exp != 8'hFF) begin
                  drop_exp++;
               end
            end
            tx_en_now = tx_en_next;
            // RX: judge a packet by its length when tlast arrives
            end_next = 0;
            if (s_axis.tvalid && rdy_exp) begin
               idle_cnt = 0;
               if (!long_f) pkt.push_back(s_axis.tdata);
               if (s_axis.tlast) begin
                  if (!long_f) begin
                     if (pkt.size() == 4) begin
                        frame_exp = {pkt[0], pkt[1], pkt[2], pkt[3]};
                        end_next = 1;
                     end else if (err_exp != 8'hFF) err_exp++;
                  end
                  pkt.delete(); long_f = 0;
               end else if (!long_f && pkt.size() == 4) begin
                  if (err_exp != 8'hFF) err_exp++;
                  long_f = 1; pkt.delete();
               end
            end else if (!long_f && pkt.size() != 0) begin
               idle_cnt++;
               if (idle_cnt == 64) begin
                  if (err_exp != 8'hFF) err_exp++;
                  pkt.delete(); idle_cnt = 0;
               end
            end
            end_now = end_next;
            rdy_exp = 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rx_beat(input logic [31:0] d, input logic l);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = d;
      s_axis.tlast  = l;
      tick();
   endtask

   task automatic rx_idle(input int n);
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
      repeat (n) tick();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int pos;
      int len;
      logic [31:0]  w[4];
      logic [127:0] f;

      m_axis.tready = 1'b1;
      s_axis.tvalid = 1'b0;
      s_axis.tdata  = '0;
      s_axis.tlast  = 1'b0;

      // Reset state
      tick();
      mon_en = 1'b1;
      check("rst_tready", s_axis.tready, 1'b0);
      check("rst_tvalid", m_axis.tvalid, 1'b0);
      check("rst_frame", rx_frame, 128'h0);
      check("rst_drop", drop_cnt, 8'h0);
      check("rst_err", err_cnt, 8'h0);
      tick();
      rst_n = 1'b1;
      tick();
      check("tready_up", s_axis.tready, 1'b1);

      // TX with tready high: start-to-o_tx_en latency
      start = 1'b1;
      tx_frame = 128'h0001_0002_AAAA_AAAA_BBBB_BBBB_CCCC_CCCC;
      tick();
      start = 1'b0;
      n = 1;
      while (!tx_en && n < 20) begin tick(); n++; end
      check("tx_latency", n, 5);
      tick();

      // TX backpressure on the second beat plus a start while sending
      start = 1'b1;
      tx_frame = {$urandom, $urandom, $urandom, $urandom};
      tick();
      start = 1'b0;
      tick();
      m_axis.tready = 1'b0;
      start = 1'b1;
      tx_frame = {$urandom, $urandom, $urandom, $urandom};
      tick();
      start = 1'b0;
      tick(); tick();
      m_axis.tready = 1'b1;
      n = 5;
      while (!tx_en && n < 30) begin tick(); n++; end
      check("tx_bp_latency", n, 8);
      check("tx_drop_one", drop_cnt, 8'd1);
      tick();

      // RX good frame
      rx_beat(32'h00001111, 1'b0);
      rx_beat(32'h00000002, 1'b0);
      rx_beat(32'h12345678, 1'b0);
      rx_beat(32'h9ABCDEF0, 1'b1);
      check("rx_good_flag", end_flag, 1'b1);
      check("rx_good_frame", rx_frame, 128'h00001111_00000002_12345678_9ABCDEF0);
      rx_idle(1);
      check("rx_flag_once", end_flag, 1'b0);

      // RX short then long frame
      rx_beat(32'h11111111, 1'b0);
      rx_beat(32'h22222222, 1'b1);
      rx_idle(1);
      check("rx_short_err", err_cnt, 8'd1);
      for (int i = 0; i < 6; i++) rx_beat($urandom, i == 5);
      rx_idle(1);
      check("rx_long_err", err_cnt, 8'd2);
      check("rx_long_frame_kept", rx_frame, 128'h00001111_00000002_12345678_9ABCDEF0);

      // RX good frame after errors
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      f = {w[0], w[1], w[2], w[3]};
      for (int i = 0; i < 4; i++) rx_beat(w[i], i == 3);
      check("rx_after_err", rx_frame, f);
      rx_idle(1);

      // RX timeout boundary: 63 idle cycles survive, the 64th discards
      rx_beat(32'hDEAD0001, 1'b0);
      rx_beat(32'hDEAD0002, 1'b0);
      rx_idle(63);
      check("rx_tmo_63", err_cnt, 8'd2);
      rx_idle(1);
      check("rx_tmo_64", err_cnt, 8'd3);
      check("rx_tmo_idle", rx_state, 2'd0);
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      f = {w[0], w[1], w[2], w[3]};
      for (int i = 0; i < 4; i++) rx_beat(w[i], i == 3);
      check("rx_after_tmo", rx_frame, f);
      rx_idle(1);

      // Randomized traffic on both directions at once
      pos = 0;
      len = 4;
      for (int c = 0; c < 3000; c++) begin
         if (c % 700 == 350) begin
            start = 1'b0;
            rx_idle(70);
         end
         start = ($urandom_range(0, 7) == 0);
         tx_frame = {$urandom, $urandom, $urandom, $urandom};
         m_axis.tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) != 0) begin
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = $urandom;
            s_axis.tlast  = (pos == len - 1);
            pos++;
            if (pos == len) begin
               pos = 0;
               len = ($urandom_range(0, 1) != 0) ? 4 : $urandom_range(1, 6);
            end
         end else begin
            s_axis.tvalid = 1'b0;
            s_axis.tlast  = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      m_axis.tready = 1'b1;
      rx_idle(10);

      // Reset in the middle of a TX frame
      start = 1'b1;
      tx_frame = {$urandom, $urandom, $urandom, $urandom};
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_tvalid", m_axis.tvalid, 1'b0);
      check("mid_rst_busy", tx_busy, 1'b0);
      check("mid_rst_drop", drop_cnt, 8'd0);
      check("mid_rst_err", err_cnt, 8'd0);
      n = 0;
      repeat (10) begin
         tick();
         if (tx_en) n++;
      end
      check("mid_rst_no_tx_en", n, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
